// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one lower-level memory port between the ICACHE and
// DCACHE miss/flush paths. Round-robin, one outstanding transaction, grant
// locked from acceptance until the response is handed back to the winner.
// Optional watchdog: define L1_ARB_WATCHDOG_EN to build the WAIT-state
// timeout counter driving the sticky watchdog_err flag.
module l1_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_rdata,
  input  logic              dc_req_valid,
  input  logic [1:0]        dc_req_op,
  input  logic [1:0]        dc_req_size,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [1:0]        mem_req_op,
  output logic [1:0]        mem_req_size,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [1:0]        mem_req_src,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              watchdog_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] SRC_IC     = 2'd1;
  localparam logic [1:0] SRC_DC     = 2'd2;
  localparam logic [1:0] OP_STORE   = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_CLFLUSH = 2'b11;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  // Stores and flushes carry no read data back to the DCACHE.
  function automatic logic op_returns_data(input logic [1:0] op);
    return !((op == OP_STORE) || (op == OP_CLFLUSH));
  endfunction

  state_e            state_q;
  logic              last_dc_q;   // 1: DCACHE was granted last
  logic [1:0]        src_q;
  logic [1:0]        op_q;
  logic              mem_req_valid_q;
  logic [1:0]        mem_req_op_q;
  logic [1:0]        mem_req_size_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [DATA_W-1:0] mem_req_wdata_q;
  logic [1:0]        mem_req_src_q;
  logic              ic_resp_valid_q;
  logic [DATA_W-1:0] ic_resp_rdata_q;
  logic              dc_resp_valid_q;
  logic [DATA_W-1:0] dc_resp_rdata_q;

  logic              grant_ic_s;
  logic              grant_dc_s;
  logic [1:0]        src_d;
  logic [1:0]        op_d;
  logic [1:0]        size_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Round-robin winner selection; only possible in IDLE and outside reset.
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (!reset && (state_q == S_IDLE)) begin
      if (ic_req_valid && dc_req_valid) begin
        grant_ic_s = last_dc_q;
        grant_dc_s = !last_dc_q;
      end else begin
        grant_ic_s = ic_req_valid;
        grant_dc_s = dc_req_valid;
      end
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  // Request fields of the winner; ICACHE fills are always word loads.
  always_comb begin
    src_d   = SRC_DC;
    op_d    = dc_req_op;
    size_d  = dc_req_size;
    addr_d  = dc_req_addr;
    wdata_d = dc_req_wdata;
    if (grant_ic_s) begin
      src_d   = SRC_IC;
      op_d    = OP_LOAD;
      size_d  = SIZE_WORD;
      addr_d  = ic_req_addr;
      wdata_d = '0;
    end else begin
      src_d   = SRC_DC;
    end
  end

  // Arbiter FSM with registered memory-request and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      last_dc_q       <= 1'b1;
      src_q           <= 2'b00;
      op_q            <= 2'b00;
      mem_req_valid_q <= 1'b0;
      mem_req_op_q    <= 2'b00;
      mem_req_size_q  <= 2'b00;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_src_q   <= 2'b00;
      ic_resp_valid_q <= 1'b0;
      ic_resp_rdata_q <= '0;
      dc_resp_valid_q <= 1'b0;
      dc_resp_rdata_q <= '0;
    end else begin
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_ic_s || grant_dc_s) begin
            state_q         <= S_ISSUE;
            last_dc_q       <= grant_dc_s;
            src_q           <= src_d;
            op_q            <= op_d;
            mem_req_valid_q <= 1'b1;
            mem_req_op_q    <= op_d;
            mem_req_size_q  <= size_d;
            mem_req_addr_q  <= addr_d;
            mem_req_wdata_q <= wdata_d;
            mem_req_src_q   <= src_d;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            state_q         <= S_WAIT;
            mem_req_valid_q <= 1'b0;
            mem_req_op_q    <= 2'b00;
            mem_req_size_q  <= 2'b00;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            mem_req_src_q   <= 2'b00;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state_q <= S_RESP;
            if (src_q == SRC_IC) begin
              ic_resp_valid_q <= 1'b1;
              ic_resp_rdata_q <= mem_resp_rdata;
            end else begin
              dc_resp_valid_q <= 1'b1;
              dc_resp_rdata_q <= op_returns_data(op_q) ? mem_resp_rdata : '0;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ic_req_ready  = grant_ic_s;
  assign dc_req_ready  = grant_dc_s;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_op    = mem_req_op_q;
  assign mem_req_size  = mem_req_size_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_src   = mem_req_src_q;
  assign ic_resp_valid = ic_resp_valid_q;
  assign ic_resp_rdata = ic_resp_rdata_q;
  assign dc_resp_valid = dc_resp_valid_q;
  assign dc_resp_rdata = dc_resp_rdata_q;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef L1_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             wd_err_q;

  // WAIT-state cycle counter; saturates at the limit, error stays sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else if ((state_q == S_ISSUE) && mem_req_ready) begin
      wd_cnt_q <= '0;
    end else if ((state_q == S_WAIT) && !mem_resp_valid) begin
      if (wd_cnt_q != TO_LIM) begin
        wd_cnt_q <= wd_cnt_q + CNT_ONE;
        if ((wd_cnt_q + CNT_ONE) == TO_LIM) begin
          wd_err_q <= 1'b1;
        end
      end
    end
  end

  assign watchdog_err = wd_err_q;
`else
  assign watchdog_err = 1'b0;
`endif

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares a single lower-level memory port between the ICACHE and DCACHE L1 miss/flush paths.
- Round-robin arbitration with one outstanding transaction at a time.
- Grant is locked from request acceptance until the memory response is returned to the winner.
- Sits between the two L1 controllers and the L2/main-memory interface; tags each memory request with its source L1 type.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_req_valid  in  1  ICACHE request; held until accepted
- ic_req_addr  in  ADDR_W  ICACHE fill address
- ic_req_ready  out  1  ICACHE request accepted this cycle
- ic_resp_valid  out  1  one-cycle ICACHE response strobe
- ic_resp_rdata  out  DATA_W  ICACHE fill data
- dc_req_valid  in  1  DCACHE request; held until accepted
- dc_req_op  in  2  STORE=00, LOAD=01, CLFLUSH=11
- dc_req_size  in  2  BYTE=00, HALF=01, WORD=10
- dc_req_addr  in  ADDR_W  DCACHE address
- dc_req_wdata  in  DATA_W  DCACHE store data
- dc_req_ready  out  1  DCACHE request accepted this cycle
- dc_resp_valid  out  1  one-cycle DCACHE response strobe
- dc_resp_rdata  out  DATA_W  DCACHE load data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_op  out  2  operation
- mem_req_size  out  2  access size
- mem_req_addr  out  ADDR_W  address
- mem_req_wdata  out  DATA_W  store data
- mem_req_src  out  2  UNASSIGNED=0, ICACHE=1, DCACHE=2
- mem_resp_valid  in  1  memory response strobe
- mem_resp_rdata  in  DATA_W  response data
- watchdog_err  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner is chosen combinationally from the valid requesters.
  - If both are valid, the requester not granted last wins. last_grant resets to DCACHE, so ICACHE wins the first tie.
  - Winner's req_ready = 1 in the same cycle (ready only ever asserts in IDLE).
  - Winner's fields are captured into request registers; last_grant is updated; next state is ISSUE.
  - ICACHE requests are captured as op=LOAD, size=WORD, wdata=0.
- ISSUE:
  - mem_req_valid = 1 with the registered fields held stable.
  - mem_req_src = the winner's type.
  - When mem_req_ready = 1, next state is WAIT; otherwise hold.
- WAIT:
  - On mem_resp_valid, capture rdata and go to RESP.
  - mem_resp_valid arriving in any other state is ignored.
- RESP:
  - Winner's resp_valid = 1 for exactly one cycle, with rdata from the capture. rdata is driven 0 when op is STORE or CLFLUSH.
  - Next state is IDLE.
- Minimum latency: acceptance at cycle T; mem_req_valid at T+1. With mem_req_ready=1 at T+1 and mem_resp_valid at T+2, resp_valid is at T+3.
- A new request can be accepted in the cycle after RESP. Back-to-back alternation occurs when both requesters are held valid.
- mem_req_* outputs are 0 when not in ISSUE; mem_req_src = UNASSIGNED.
- resp_rdata outputs hold their value when resp_valid is low.
- Reset, including mid-transaction: state → IDLE, last_grant → DCACHE, outstanding transaction dropped, all outputs 0 (watchdog_err included).
- A requester dropping valid before ready is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro: L1_ARB_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each cycle in WAIT.
  - When the count reaches TIMEOUT_CYCLES without mem_resp_valid, watchdog_err is set and stays set until reset.
  - The FSM keeps waiting; the counter saturates.
- Undefined: no counter is built and watchdog_err is tied to 0.

Test Plan:
- ic_req_valid only, addr=0x100, mem_req_ready=1, response 0xDEADBEEF one cycle later → mem_req op=LOAD, size=WORD, src=1, addr=0x100; ic_resp_valid pulse with 0xDEADBEEF at T+3; dc_resp_valid stays 0.
- Both requesters valid after reset, held through 3 transactions → grant order ICACHE, DCACHE, ICACHE; each ready pulses exactly once per grant.
- DCACHE STORE, size=BYTE, addr=0x23, wdata=0xAB; mem_req_ready held low 4 cycles → mem_req fields stable for all 5 ISSUE cycles; dc_resp_valid after response with rdata=0.
- DCACHE CLFLUSH while ICACHE raises valid during WAIT → ic_req_ready stays 0 until after dc_resp_valid, then ICACHE is granted next cycle.
- Reset asserted in WAIT, then stale mem_resp_valid after reset → all outputs 0, no resp_valid generated, next tie goes to ICACHE.
- With L1_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=8, no memory response → watchdog_err rises after 8 WAIT cycles and stays high; a later response still completes the transaction.
